// File: rtl/barrel_shifter_if.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shifter_if
//  Description : Operand/result bundle for the barrel shifter. The master
//                side supplies the operand and shift controls, the slave
//                side returns the registered result.
//  Revision    : 1.0 - initial release
// ============================================================================
interface barrel_shifter_if #(
    parameter int WIDTH = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic               in_valid;
    logic [WIDTH-1:0]   in;
    logic [SHW-1:0]     shift;
    logic               dir;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   out;
    logic               out_valid;

    modport master (
        output in_valid, in, shift, dir, mode,
        input  out, out_valid
    );

    modport slave (
        input  in_valid, in, shift, dir, mode,
        output out, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shifter
//  Description : Single-cycle logical / arithmetic / rotate barrel shifter
//                with a registered result. Shift amount 0..WIDTH-1, left or
//                right. The shift network is a log2(WIDTH)-stage mux tree;
//                stage k moves the data by 2^k when shift[k] is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shifter #(
    parameter int WIDTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    barrel_shifter_if.slave     bus
);
    localparam int               SHW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    // mode[1] selects rotate for both 10 and 11
    logic               w_rot;
    // vacated-bit value for right shifts: sign bit only for arithmetic right
    logic               w_fill;
    logic [WIDTH-1:0]   w_result;

    logic [WIDTH-1:0]   out_d, out_q;
    logic               out_valid_d, out_valid_q;

    // Decode the mode into rotate select and right-shift fill bit
    always_comb begin
        w_rot  = bus.mode[1];
        w_fill = (bus.mode == 2'b01) && bus.dir && bus.in[WIDTH-1];
    end

    // Mux tree: each stage conditionally moves the running value by 2^k
    always_comb begin
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] fill_mask;
        data      = bus.in;
        fill_mask = '0;
        for (int k = 0; k < SHW; k++) begin
            if (bus.shift[k]) begin
                if (bus.dir) begin
                    // Mask of the 2^k MSB positions vacated by a right move
                    fill_mask = ~(ONES >> (1 << k));
                    if (w_rot) begin
                        data = (data >> (1 << k)) | (data << (WIDTH - (1 << k)));
                    end else begin
                        data = (data >> (1 << k)) | (w_fill ? fill_mask : '0);
                    end
                end else begin
                    if (w_rot) begin
                        data = (data << (1 << k)) | (data >> (WIDTH - (1 << k)));
                    end else begin
                        data = data << (1 << k);
                    end
                end
            end
        end
        w_result = data;
    end

    // Next-state: capture a new result only on valid cycles, otherwise hold
    always_comb begin
        out_d       = out_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            out_d = w_result;
        end
    end

    // Output register; reset wins over a same-cycle valid input
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrel_shifter
//  Description : Self-checking bench for barrel_shifter at WIDTH=4 (directed
//                vector table plus hand-written sequences) and WIDTH=8
//                (sweep of all modes, directions and shift amounts).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shifter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    barrel_shifter_if #(.WIDTH(4)) bus4 ();
    barrel_shifter_if #(.WIDTH(8)) bus8 ();

    barrel_shifter #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    barrel_shifter #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] in;
        logic [1:0] shift;
        logic       dir;
        logic [1:0] mode;
        logic [3:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle on the 4-bit DUT: drive at negedge, sample 1ns after posedge
    task automatic step4(input logic r, input logic v, input logic [3:0] i,
                         input logic [1:0] s, input logic d, input logic [1:0] m);
        @(negedge clk);
        rst           = r;
        bus4.in_valid = v;
        bus4.in       = i;
        bus4.shift    = s;
        bus4.dir      = d;
        bus4.mode     = m;
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic r, input logic v, input logic [7:0] i,
                         input logic [2:0] s, input logic d, input logic [1:0] m);
        @(negedge clk);
        rst           = r;
        bus8.in_valid = v;
        bus8.in       = i;
        bus8.shift    = s;
        bus8.dir      = d;
        bus8.mode     = m;
        bus4.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Bit-by-bit reference: each result bit picks its source bit directly
    function automatic logic [7:0] ref8(input logic [7:0] x, input int s,
                                        input logic d, input logic [1:0] m);
        logic [7:0] r;
        int src;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (!d) begin
                src = i - s;
                if (src >= 0)  r[i] = x[src];
                else if (m[1]) r[i] = x[src + 8];
                else           r[i] = 1'b0;
            end else begin
                src = i + s;
                if (src < 8)          r[i] = x[src];
                else if (m[1])        r[i] = x[src - 8];
                else if (m == 2'b01)  r[i] = x[7];
                else                  r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    initial begin
        logic [7:0] ops [3];
        logic [7:0] exp8;

        //          in       shift dir mode   expected
        vecs[0]  = '{4'b1010, 2'd1, 1'b0, 2'b00, 4'b0100};
        vecs[1]  = '{4'b1010, 2'd2, 1'b1, 2'b00, 4'b0010};
        vecs[2]  = '{4'b1010, 2'd3, 1'b0, 2'b00, 4'b0000};
        vecs[3]  = '{4'b1010, 2'd0, 1'b0, 2'b00, 4'b1010};
        vecs[4]  = '{4'b1010, 2'd0, 1'b1, 2'b00, 4'b1010};
        vecs[5]  = '{4'b1010, 2'd3, 1'b1, 2'b00, 4'b0001};
        vecs[6]  = '{4'b1010, 2'd1, 1'b1, 2'b01, 4'b1101};
        vecs[7]  = '{4'b1010, 2'd3, 1'b1, 2'b01, 4'b1111};
        vecs[8]  = '{4'b1010, 2'd1, 1'b0, 2'b01, 4'b0100};
        vecs[9]  = '{4'b0110, 2'd2, 1'b1, 2'b01, 4'b0001};
        vecs[10] = '{4'b1010, 2'd0, 1'b1, 2'b01, 4'b1010};
        vecs[11] = '{4'b1010, 2'd1, 1'b0, 2'b10, 4'b0101};
        vecs[12] = '{4'b1010, 2'd2, 1'b1, 2'b10, 4'b1010};
        vecs[13] = '{4'b1010, 2'd3, 1'b0, 2'b10, 4'b0101};
        vecs[14] = '{4'b1000, 2'd1, 1'b1, 2'b11, 4'b0100};
        vecs[15] = '{4'b1011, 2'd1, 1'b0, 2'b10, 4'b0111};
        vecs[16] = '{4'b0001, 2'd1, 1'b1, 2'b11, 4'b1000};
        vecs[17] = '{4'b0110, 2'd3, 1'b1, 2'b10, 4'b1100};

        bus4.in_valid = 1'b0; bus4.in = '0; bus4.shift = '0; bus4.dir = 1'b0; bus4.mode = '0;
        bus8.in_valid = 1'b0; bus8.in = '0; bus8.shift = '0; bus8.dir = 1'b0; bus8.mode = '0;

        // Reset held two cycles with a valid all-ones input that must be dropped
        for (int c = 0; c < 2; c++) begin
            step4(1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 2'b00);
            check("rst_out", {4'h0, bus4.out}, 8'h00);
            check("rst_valid", {7'd0, bus4.out_valid}, 8'h00);
        end
        step4(1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 2'b00);
        check("post_rst_valid", {7'd0, bus4.out_valid}, 8'h00);
        check("post_rst_out", {4'h0, bus4.out}, 8'h00);

        // Directed vectors, applied back to back
        for (int n = 0; n < NVEC; n++) begin
            step4(1'b0, 1'b1, vecs[n].in, vecs[n].shift, vecs[n].dir, vecs[n].mode);
            check($sformatf("vec%0d_out", n), {4'h0, bus4.out}, {4'h0, vecs[n].exp});
            check($sformatf("vec%0d_valid", n), {7'd0, bus4.out_valid}, 8'h01);
        end

        // Back-to-back then hold
        step4(1'b0, 1'b1, 4'b0001, 2'd1, 1'b0, 2'b00);
        check("b2b1_out", {4'h0, bus4.out}, 8'h02);
        check("b2b1_valid", {7'd0, bus4.out_valid}, 8'h01);
        step4(1'b0, 1'b1, 4'b0001, 2'd2, 1'b0, 2'b00);
        check("b2b2_out", {4'h0, bus4.out}, 8'h04);
        check("b2b2_valid", {7'd0, bus4.out_valid}, 8'h01);
        step4(1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 2'b00);
        check("hold_out", {4'h0, bus4.out}, 8'h04);
        check("hold_valid", {7'd0, bus4.out_valid}, 8'h00);
        // Unknown operand while idle must not disturb the held result
        step4(1'b0, 1'b0, 4'bxxxx, 2'bxx, 1'bx, 2'bxx);
        check("x_idle_out", {4'h0, bus4.out}, 8'h04);
        check("x_idle_valid", {7'd0, bus4.out_valid}, 8'h00);

        // Reset mid-stream: valid input on the reset edge is discarded
        step4(1'b0, 1'b1, 4'b1010, 2'd1, 1'b1, 2'b10);
        check("pre_mid_rst_out", {4'h0, bus4.out}, 8'h05);
        step4(1'b1, 1'b1, 4'b1111, 2'd1, 1'b0, 2'b00);
        check("mid_rst_out", {4'h0, bus4.out}, 8'h00);
        check("mid_rst_valid", {7'd0, bus4.out_valid}, 8'h00);
        step4(1'b0, 1'b0, 4'b1111, 2'd1, 1'b0, 2'b00);
        check("after_mid_rst_out", {4'h0, bus4.out}, 8'h00);
        check("after_mid_rst_valid", {7'd0, bus4.out_valid}, 8'h00);

        // WIDTH=8 sweep over every mode, direction and shift amount
        ops[0] = 8'hA5;
        ops[1] = 8'h3C;
        ops[2] = 8'($urandom);
        for (int o = 0; o < 3; o++) begin
            for (int m = 0; m < 4; m++) begin
                for (int d = 0; d < 2; d++) begin
                    for (int s = 0; s < 8; s++) begin
                        exp8 = ref8(ops[o], s, d[0], m[1:0]);
                        step8(1'b0, 1'b1, ops[o], s[2:0], d[0], m[1:0]);
                        check($sformatf("w8 op%0d m%0d d%0d s%0d", o, m, d, s), bus8.out, exp8);
                    end
                end
            end
        end
        check("w8_valid", {7'd0, bus8.out_valid}, 8'h01);
        step8(1'b1, 1'b1, 8'hFF, 3'd3, 1'b1, 2'b01);
        check("w8_rst_out", bus8.out, 8'h00);
        check("w8_rst_valid", {7'd0, bus8.out_valid}, 8'h00);
        step8(1'b0, 1'b1, 8'h81, 3'd7, 1'b1, 2'b01);
        check("w8_arith_max", bus8.out, 8'hFF);
        check("w8_arith_max_valid", {7'd0, bus8.out_valid}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- Parameterised single-cycle barrel shifter with a registered output: shifts or rotates a WIDTH-bit operand left or right by 0..WIDTH-1 positions.
- Used as a datapath utility, for example in ALU shift units and field alignment.
- Shift network is a log2(WIDTH)-stage mux tree: stage k conditionally moves data by 2^k.
- One output register stage; one clock; synchronous active-high reset.

Parameters:
- WIDTH, 4, operand/result width in bits; power of two, >= 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  qualifies in/shift/dir/mode this cycle
- in  input  WIDTH  operand
- shift  input  SHW  shift amount, 0..WIDTH-1
- dir  input  1  0 = left, 1 = right
- mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 rotate (alias)
- out  output  WIDTH  registered result
- out_valid  output  1  out holds a result computed from an in_valid cycle

Behaviour:
- Reset: rst sampled high at posedge sets out = 0 and out_valid = 0. rst has priority over in_valid in the same cycle.
- Latency is exactly 1 cycle. Inputs are sampled at posedge N when in_valid=1; the result appears on out with out_valid=1 after that edge.
- in_valid=0 at an edge (rst low):
  - out holds its previous value.
  - out_valid deasserts to 0.
- Throughput is one operation per cycle. No backpressure.
- Logical (mode 00):
  - dir=0: out = in << shift, zero-filled at LSBs.
  - dir=1: out = in >> shift, zero-filled at MSBs.
- Arithmetic (mode 01):
  - dir=1: sign-extending right shift; vacated MSBs are copied from in[WIDTH-1].
  - dir=0: identical to a logical left shift.
- Rotate (mode 10/11):
  - dir=0: bits leaving the MSB re-enter at the LSB.
  - dir=1: bits leaving the LSB re-enter at the MSB.
- shift = 0: out = in for every mode and direction.
- shift = WIDTH-1 (maximum):
  - logical left leaves only in[0], at MSB.
  - logical right leaves only in[WIDTH-1], at LSB.
  - arithmetic right gives all bits = in[WIDTH-1].
- Because shift is SHW bits wide, shift amounts >= WIDTH cannot be expressed; there is no modulo case.
- Rotate equivalence: rotate left by s equals rotate right by (WIDTH-s) mod WIDTH.
- Unknown/X inputs with in_valid=0 must not affect out.
- Datapath is purely combinational between the input pins and the output register. No other state and no FSM.
- Reset asserted mid-stream: the next edge clears out/out_valid regardless of in_valid. A valid input on the edge where rst is high is discarded, not queued.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in=4'b1111 -> out=0000, out_valid=0; after release with in_valid=0, out_valid stays 0.
- Logical, in=4'b1010:
  - shift=1, dir=0 -> out=0100.
  - shift=2, dir=1 -> out=0010.
  - shift=3, dir=0 -> out=0000.
  - shift=0, either dir -> out=1010.
  - Each result one cycle after its in_valid edge.
- Arithmetic, in=4'b1010:
  - shift=1, dir=1 -> 1101.
  - shift=3, dir=1 -> 1111.
  - shift=1, dir=0 -> 0100.
  - in=0110, shift=2, dir=1 -> 0001.
- Rotate, in=4'b1010, mode=10:
  - shift=1, dir=0 -> 0101.
  - shift=2, dir=1 -> 1010.
  - shift=3, dir=0 -> 0101.
  - mode=11 with in=1000, shift=1, dir=1 -> 0100.
- Back-to-back and hold, logical mode:
  - Edge 1: in_valid=1, in=0001, shift=1, dir=0. Edge 2: in_valid=1, in=0001, shift=2, dir=0. Edge 3: in_valid=0, in=1111.
  - Response: out=0010 (valid), then 0100 (valid), then 0100 with out_valid=0.
- Randomised sweep with WIDTH=8 and WIDTH=4, all modes, dirs and shift amounts -> out matches a reference shift/rotate computed one cycle earlier. Include rst pulsed mid-stream: the cycle after the rst edge shows out=0, out_valid=0.
